gf_horner_eval: RTL and testbench
=================================

# gf_horner_eval

Sequential polynomial evaluator over GF(2^32). Computes r = c0·x^(N-1) ⊕ c1·x^(N-2) ⊕ … ⊕ c(N-1) by Horner's rule. The field is defined by P(z) = z^32 + poly, and x is a 9-bit field element (degree ≤ 8). The multiply acc·x is bit-serial: one multiplier bit per cycle, MSB first, with the same shift-reduce-conditional-XOR step as the team's combinational GF multiplier. The block sits downstream of coefficient generation and consumes a streamed coefficient vector through a valid/ready handshake.

## Interface
- No parameters. Field width is fixed at 32 bits; multiplier width is fixed at 9 bits.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a new evaluation; honoured only in IDLE
- poly  in  32  low 32 coefficients of P(z); z^32 is implicit; latched on accepted start
- x  in  9  evaluation point; latched on accepted start
- coef_valid  in  1  coefficient available
- coef_data  in  32  coefficient, highest power first
- coef_last  in  1  marks the final coefficient; qualified by coef_valid
- coef_ready  out  1  block can accept a coefficient
- res_valid  out  1  result available
- res_data  out  32  evaluation result
- res_ready  in  1  downstream accepts the result
- busy  out  1  high in every state except IDLE

## Operation
- Registers:
  - poly_r, x_r: latched on start
  - acc: 32-bit Horner accumulator
  - t: 32-bit partial product
  - c_r: latched coefficient
  - last_r: latched last flag
  - cnt: 4-bit bit index
  - state
- IDLE:
  - When start=1, latch poly_r and x_r, clear acc, go to ACC.
- ACC:
  - coef_ready=1.
  - On coef_valid & coef_ready: c_r ← coef_data, last_r ← coef_last, t ← 0, cnt ← 8, go to MUL.
- MUL (exactly 9 cycles, cnt = 8 down to 0):
  - s = t[31] ? ({t[30:0],0} ⊕ poly_r) : {t[30:0],0}
  - t ← s ⊕ (x_r[cnt] ? acc : 0)
  - On the cycle with cnt=0: acc ← (that same next-t value) ⊕ c_r. Then go to DONE if last_r, else go to ACC.
- DONE:
  - res_valid=1 and res_data=acc, both held stable until res_ready=1.
  - On res_valid & res_ready, go to IDLE.
- Field arithmetic is carry-less throughout. There is no integer add anywhere, and all widths are exactly 32 bits.
- start is ignored outside IDLE. poly and x changes after the latch have no effect.
- coef_valid is ignored outside ACC. The upstream must hold coef_data and coef_last stable until the handshake completes.
- A coefficient with coef_last=1 as the first coefficient gives res_data = that coefficient, because acc=0 going into its multiply.
- x=0: result equals the last coefficient. x=1: result equals the XOR of all coefficients.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE
  - acc, t, c_r, poly_r, x_r = 0; cnt=0; last_r=0
  - coef_ready=0, res_valid=0, res_data=0, busy=0
- Reset mid-operation aborts the evaluation. No res_valid pulse is produced.
- Cycle numbering: start sampled at cycle 0. ACC is entered at cycle 1, and coef_ready is high from cycle 1.
- Coefficient k accepted in cycle a occupies MUL in cycles a+1 … a+9.
  - Non-last: ACC again at a+10.
  - Last: DONE at a+10.
- Throughput: 1 coefficient per 10 cycles.
- With no stalls, N coefficients give res_valid first high at cycle 1+10N.
- If res_ready=1 in the first DONE cycle: IDLE at the next cycle, and a new start can be taken there.
- coef_ready and res_valid are decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- Wrap/reduction: poly=0x04C11DB7, x=2, coefs [0x80000000, 0x00000000(last)] → res_data=0x04C11DB7, res_valid first high at cycle 21.
- Basic multiply: poly=0x04C11DB7, x=3, coefs [5, 0(last)] → 0x0000000F. Also x=0x100, coefs [1, 0(last)] → 0x00000100 (checks the MSB multiplier bit).
- x=1, coefs [0x1234, 0x00FF, 0xF000(last)] → 0x0000E2CB. Same coefs with x=0 → 0x0000F000.
- Handshake stalls:
  - Random coef_valid gaps and res_ready held low for 5 cycles → result unchanged, res_data stable while res_valid=1.
  - coef_ready low throughout MUL.
  - start pulsed during ACC, MUL and DONE → ignored.
- Single coefficient 0xDEADBEEF with last=1 → 0xDEADBEEF at cycle 11.
- rst_n=0 in the 4th MUL cycle → next cycle all outputs 0 and state IDLE. A fresh evaluation afterwards gives the correct value with no residue from the aborted run.

Source files
------------

// File: rtl/gf_horner_eval.sv
// -----------------------------------------------------------------------------
// gf_horner_eval
//
// Sequential polynomial evaluator over GF(2^32) using Horner's rule:
//   r = c0*x^(N-1) ^ c1*x^(N-2) ^ ... ^ c(N-1)
// The field is defined by P(z) = z^32 + poly. The evaluation point x is a
// 9-bit field element. Each Horner step multiplies the accumulator by x
// bit-serially (one multiplier bit per cycle, MSB first) and then folds in
// the next coefficient, so one coefficient is consumed every 10 cycles.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   start       begin a new evaluation (honoured only when idle)
//   poly        low 32 coefficients of P(z), latched on accepted start
//   x           9-bit evaluation point, latched on accepted start
//   coef_valid  upstream coefficient available
//   coef_data   coefficient, highest power first
//   coef_last   marks the final coefficient (qualified by coef_valid)
//   coef_ready  block can accept a coefficient
//   res_valid   result available, held until res_ready
//   res_data    evaluation result
//   res_ready   downstream accepts the result
//   busy        high whenever an evaluation is in progress
// -----------------------------------------------------------------------------
module gf_horner_eval (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] poly,
    input  logic [8:0]  x,
    input  logic        coef_valid,
    input  logic [31:0] coef_data,
    input  logic        coef_last,
    output logic        coef_ready,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] poly_r;
    logic [8:0]  x_r;
    logic [31:0] acc;
    logic [31:0] t;
    logic [31:0] c_r;
    logic        last_r;
    logic [3:0]  cnt;

    // One shift-reduce-conditional-XOR step of the MSB-first multiplier.
    logic [31:0] t_shift;
    logic [31:0] t_reduced;
    logic [31:0] t_next;
    logic [31:0] acc_next;

    // NOTE: every always_comb output gets a value on every path; here each is
    // a plain expression, so no path can leave one unassigned and infer a latch.
    always_comb begin
        t_shift   = {t[30:0], 1'b0};
        t_reduced = t[31] ? (t_shift ^ poly_r) : t_shift;
        t_next    = t_reduced ^ (x_r[cnt] ? acc : 32'd0);
        acc_next  = t_next ^ c_r;
    end

    // The accumulator is only written at the end of a Horner step and held
    // through DONE, so it doubles as the result register.
    assign res_data = acc;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the reset is synchronous, sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            poly_r     <= 32'd0;
            x_r        <= 9'd0;
            acc        <= 32'd0;
            t          <= 32'd0;
            c_r        <= 32'd0;
            last_r     <= 1'b0;
            cnt        <= 4'd0;
            coef_ready <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        poly_r     <= poly;
                        x_r        <= x;
                        acc        <= 32'd0;
                        state      <= ACC;
                        coef_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ACC: begin
                    // coef_ready is a registered copy of (state == ACC).
                    if (coef_valid) begin
                        c_r        <= coef_data;
                        last_r     <= coef_last;
                        t          <= 32'd0;
                        cnt        <= 4'd8;
                        state      <= MUL;
                        coef_ready <= 1'b0;
                    end
                end

                MUL: begin
                    t <= t_next;
                    if (cnt == 4'd0) begin
                        // Final multiplier bit: fold the coefficient into the
                        // freshly completed product acc*x.
                        acc <= acc_next;
                        if (last_r) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state      <= ACC;
                            coef_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    coef_ready <= 1'b0;
                    res_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_horner_eval.sv
// -----------------------------------------------------------------------------
// tb_gf_horner_eval
//
// Directed bench for gf_horner_eval. Expected results are hand-computed
// GF(2^32) values; latency is measured in cycles counted from the edge that
// samples start (that edge is cycle 0).
// -----------------------------------------------------------------------------
module tb_gf_horner_eval;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] poly;
    logic [8:0]  x;
    logic        coef_valid;
    logic [31:0] coef_data;
    logic        coef_last;
    logic        coef_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [31:0] coefs [8];

    gf_horner_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .poly       (poly),
        .x          (x),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_last  (coef_last),
        .coef_ready (coef_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs one evaluation. gaps inserts random coef_valid bubbles, stall holds
    // res_ready low for that many DONE cycles, poke drives start (with junk
    // poly/x) throughout the busy period. exp_cycles=0 skips the latency check.
    task automatic run_eval(input string tag, input logic [31:0] p, input logic [8:0] xv,
                            input int n, input logic [31:0] exp, input bit gaps,
                            input int stall, input bit poke, input int exp_cycles);
        int  cyc;
        int  idx;
        int  since;
        bit  hs;
        bit  ready_in_mul;
        poly  = p;
        x     = xv;
        start = 1'b1;
        tick();
        start        = 1'b0;
        cyc          = 1;
        idx          = 0;
        since        = 99;
        ready_in_mul = 1'b0;
        while (!res_valid && cyc < 300) begin
            if (poke) begin
                start = 1'b1;
                poly  = $urandom;
                x     = 9'($urandom);
            end
            if (!coef_valid && idx < n && (!gaps || $urandom_range(0, 2) == 0)) begin
                coef_valid = 1'b1;
                coef_data  = coefs[idx];
                coef_last  = (idx == n - 1);
            end
            hs = coef_valid && coef_ready;
            tick();
            cyc++;
            if (hs) begin
                idx++;
                coef_valid = 1'b0;
                coef_data  = $urandom;
                coef_last  = 1'b0;
                since      = 0;
            end
            if (since < 9) begin
                if (coef_ready) ready_in_mul = 1'b1;
                since++;
            end
        end
        check({tag, " res_valid"}, 64'(res_valid), 64'd1);
        if (exp_cycles > 0) check({tag, " latency"}, 64'(cyc), 64'(exp_cycles));
        check({tag, " res_data"}, 64'(res_data), 64'(exp));
        check({tag, " coef_ready in MUL"}, 64'(ready_in_mul), 64'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check($sformatf("%s stall%0d valid/data", tag, s), {31'd0, res_valid, res_data}, {32'd1, exp});
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, " back to idle"}, {62'd0, busy, res_valid}, 64'd0);
        coef_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        poly       = 32'd0;
        x          = 9'd0;
        coef_valid = 1'b0;
        coef_data  = 32'd0;
        coef_last  = 1'b0;
        res_ready  = 1'b0;
        tick();
        tick();
        check("reset outputs", {29'd0, coef_ready, res_valid, busy, res_data}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle after reset", {62'd0, busy, coef_ready}, 64'd0);

        // z^31 * z = z^32, reduced to poly.
        coefs = '{32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("wrap", 32'h04C11DB7, 9'd2, 2, 32'h04C11DB7, 1'b0, 0, 1'b0, 21);

        // 5 * 3 = 101 ^ 1010 = 1111.
        coefs = '{32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("mul3", 32'h04C11DB7, 9'd3, 2, 32'h0000000F, 1'b0, 0, 1'b0, 21);

        // Only the MSB multiplier bit set.
        coefs = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("msb", 32'h04C11DB7, 9'h100, 2, 32'h00000100, 1'b0, 0, 1'b0, 21);

        // x=1: XOR of all coefficients; x=0: last coefficient.
        coefs = '{32'h1234, 32'h00FF, 32'hF000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("x1", 32'h04C11DB7, 9'd1, 3, 32'h0000E2CB, 1'b0, 0, 1'b0, 31);
        run_eval("x0", 32'h04C11DB7, 9'd0, 3, 32'h0000F000, 1'b0, 0, 1'b0, 31);

        // Single coefficient: acc is 0 going into its multiply.
        coefs = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("single", 32'h04C11DB7, 9'h1A5, 1, 32'hDEADBEEF, 1'b0, 0, 1'b0, 11);

        // Stalls on both handshakes plus start pokes with junk poly/x.
        coefs = '{32'h1234, 32'h00FF, 32'hF000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("stall x1", 32'h04C11DB7, 9'd1, 3, 32'h0000E2CB, 1'b1, 5, 1'b1, 0);
        coefs = '{32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("stall wrap", 32'h04C11DB7, 9'd2, 2, 32'h04C11DB7, 1'b1, 5, 1'b1, 0);

        // Abort in the 4th MUL cycle.
        poly       = 32'h04C11DB7;
        x          = 9'd3;
        start      = 1'b1;
        coef_valid = 1'b1;
        coef_data  = 32'hFFFFFFFF;
        coef_last  = 1'b0;
        tick();
        start = 1'b0;
        tick();
        coef_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid-MUL busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        check("abort outputs", {29'd0, coef_ready, res_valid, busy, res_data}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("abort idle", {62'd0, busy, res_valid}, 64'd0);
        coefs = '{32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_eval("after abort", 32'h04C11DB7, 9'd3, 2, 32'h0000000F, 1'b0, 0, 1'b0, 21);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
